// File: rtl/iir_coef_loader_if.sv
// Coefficient word stream: valid/ready handshake carrying data words and an end-of-frame flag.
interface iir_coef_loader_if #(
    parameter int CW = 64
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/iir_coef_loader.sv
// Runtime coefficient loader for cascaded biquads: shadow bank assembly with atomic commit on sample_tick.
// Optional trailing checksum word is enabled by defining COEF_CHECKSUM_EN.
module iir_coef_loader #(
    parameter int BITWIDTH = 32,
    parameter int NSEC     = 4,
    localparam int CW      = 2 * BITWIDTH,
    localparam int NW      = NSEC * 5
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_coef_loader_if.slave     stream,
    input  logic                 sample_tick,
    output logic [NW*CW-1:0]     coef,
    output logic                 commit,
    output logic                 busy,
    output logic                 err
);
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] PEND   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] RESYNC = 3'd4;
`ifdef COEF_CHECKSUM_EN
    localparam logic [2:0] CHECK  = 3'd5;
`endif

    logic [2:0]               state;
    logic signed [CW-1:0]     shadow [NW];
    logic signed [CW-1:0]     active [NW];
    logic [7:0]               sec;
    logic [7:0]               last_sec;
    logic [2:0]               k;
`ifdef COEF_CHECKSUM_EN
    logic [CW-1:0]            sum;
`endif

    logic                     xfer;
    logic [7:0]               hdr_s;
    logic [7:0]               hdr_m;
    logic                     hdr_ok;
    logic                     final_word;
    logic [AW-1:0]            widx;

    assign stream.ready = !rst && (state == IDLE || state == LOAD || state == DRAIN
`ifdef COEF_CHECKSUM_EN
                                   || state == CHECK
`endif
                                  );
    assign xfer       = stream.valid && stream.ready;
    assign busy       = (state != IDLE);
    assign hdr_s      = stream.data[7:0];
    assign hdr_m      = stream.data[15:8];
    // A header is usable only if it names at least one in-range section and does not end the frame.
    assign hdr_ok     = (hdr_m != 8'd0) && (({1'b0, hdr_s} + {1'b0, hdr_m}) <= 9'(NSEC)) && !stream.last;
    assign final_word = (k == 3'd4) && (sec == last_sec);
    assign widx       = AW'(11'(sec) * 11'd5 + 11'(k));

    for (genvar i = 0; i < NW; i++) begin : g_pack
        assign coef[i*CW +: CW] = active[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            err      <= 1'b0;
            commit   <= 1'b0;
            sec      <= 8'd0;
            last_sec <= 8'd0;
            k        <= 3'd0;
`ifdef COEF_CHECKSUM_EN
            sum      <= '0;
`endif
            for (int i = 0; i < NW; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            commit <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (hdr_ok) begin
                            err      <= 1'b0;
                            sec      <= hdr_s;
                            last_sec <= hdr_s + hdr_m - 8'd1;
                            k        <= 3'd0;
`ifdef COEF_CHECKSUM_EN
                            sum      <= stream.data;
`endif
                            state    <= LOAD;
                        end else begin
                            err   <= 1'b1;
                            state <= stream.last ? RESYNC : DRAIN;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        shadow[widx] <= stream.data;
`ifdef COEF_CHECKSUM_EN
                        sum <= sum + stream.data;
                        // With a checksum trailer, any in_last inside the coefficient run is premature.
                        if (stream.last) begin
                            err   <= 1'b1;
                            state <= RESYNC;
                        end else if (final_word) begin
                            state <= CHECK;
                        end
`else
                        if (stream.last && !final_word) begin
                            err   <= 1'b1;
                            state <= RESYNC;
                        end else if (final_word && !stream.last) begin
                            err   <= 1'b1;
                            state <= DRAIN;
                        end else if (final_word) begin
                            state <= PEND;
                        end
`endif
                        if (k == 3'd4) begin
                            k   <= 3'd0;
                            sec <= sec + 8'd1;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
`ifdef COEF_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        if (stream.last && stream.data == sum) begin
                            state <= PEND;
                        end else begin
                            err   <= 1'b1;
                            state <= stream.last ? RESYNC : DRAIN;
                        end
                    end
                end
`endif
                PEND: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NW; i++) active[i] <= shadow[i];
                        commit <= 1'b1;
                        state  <= IDLE;
                    end
                end
                DRAIN: begin
                    if (xfer && stream.last) state <= RESYNC;
                end
                RESYNC: begin
                    // Roll the shadow back so a partial frame never reaches a later commit.
                    for (int i = 0; i < NW; i++) shadow[i] <= active[i];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed + randomized bench for iir_coef_loader against a bank-level reference model.
module tb_iir_coef_loader;
    localparam int BITWIDTH = 32;
    localparam int NSEC     = 4;
    localparam int CW       = 2 * BITWIDTH;
    localparam int NW       = NSEC * 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_tick;
    logic [NW*CW-1:0]  coef;
    logic              commit;
    logic              busy;
    logic              err;

    iir_coef_loader_if #(.CW(CW)) bus ();

    iir_coef_loader #(.BITWIDTH(BITWIDTH), .NSEC(NSEC)) dut (
        .clk(clk), .rst(rst), .stream(bus.slave), .sample_tick(sample_tick),
        .coef(coef), .commit(commit), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] exp_active [NW];
    logic [CW-1:0] pend       [NW];
    bit            pend_mask  [NW];
    logic [CW-1:0] fw         [NW];

    task automatic chk(input string tag, input logic [NW*CW-1:0] obs, input logic [NW*CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW*CW-1:0] model_coef();
        logic [NW*CW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*CW +: CW] = exp_active[i];
        return v;
    endfunction

    function automatic logic [CW-1:0] make_hdr(input int s, input int m);
        logic [CW-1:0] h;
        h        = {$urandom, $urandom};
        h[7:0]   = 8'(s);
        h[15:8]  = 8'(m);
        return h;
    endfunction

    task automatic send(input logic [CW-1:0] d, input bit l, input bit t);
        int n;
        n = 0;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.data    = d;
        bus.last    = l;
        sample_tick = t;
        while (!bus.ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_xfer", bus.ready, 1);
        @(posedge clk);
        #1;
        bus.valid   = 1'b0;
        bus.last    = 1'b0;
        sample_tick = 1'b0;
    endtask

    // Sends header + 5*m words from fw[]; a good frame is recorded as pending in the model.
    task automatic send_frame(input int s, input int m, input bit bad_sum, input bit tick_last);
        logic [CW-1:0] h;
        logic [CW-1:0] sum;
        int nw;
        nw = 5 * m;
        h  = make_hdr(s, m);
        sum = h;
        send(h, 1'b0, 1'b0);
        chk("err_clear_on_hdr", err, 0);
        for (int i = 0; i < nw; i++) begin
            sum = sum + fw[i];
`ifdef COEF_CHECKSUM_EN
            send(fw[i], 1'b0, 1'b0);
`else
            send(fw[i], (i == nw - 1), tick_last && (i == nw - 1));
`endif
        end
`ifdef COEF_CHECKSUM_EN
        send(sum + CW'(bad_sum), 1'b1, tick_last);
`endif
        if (!bad_sum) begin
            for (int i = 0; i < nw; i++) begin
                pend[5*s + i]      = fw[i];
                pend_mask[5*s + i] = 1'b1;
            end
            chk("busy_in_pend", busy, 1);
        end
        chk("no_commit_on_last", commit, 0);
    endtask

    task automatic tick_expect(input bit exp_commit);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        if (exp_commit) begin
            for (int i = 0; i < NW; i++) begin
                if (pend_mask[i]) exp_active[i] = pend[i];
                pend_mask[i] = 1'b0;
            end
        end
        chk("commit_pulse", commit, exp_commit);
        chk("coef_after_tick", coef, model_coef());
        @(posedge clk);
        #1;
        chk("commit_one_cycle", commit, 0);
        chk("busy_after_tick", busy, 0);
    endtask

    task automatic rand_words(input int nw);
        for (int i = 0; i < nw; i++) fw[i] = {$urandom, $urandom};
    endtask

    initial begin
        int s;
        int m;
        for (int i = 0; i < NW; i++) begin
            exp_active[i] = '0;
            pend[i]       = '0;
            pend_mask[i]  = 1'b0;
            fw[i]         = '0;
        end
        rst         = 1'b1;
        bus.valid   = 1'b0;
        bus.data    = '0;
        bus.last    = 1'b0;
        sample_tick = 1'b0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", bus.ready, 0);
        chk("coef_in_reset", coef, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus.ready, 1);
        chk("busy_after_reset", busy, 0);
        chk("err_after_reset", err, 0);
        chk("commit_after_reset", commit, 0);
        chk("coef_after_reset", coef, model_coef());

        // Single-section load with the reference coefficients
        fw[0] = 64'h10_0000;
        fw[1] = 64'h20_0000;
        fw[2] = 64'h10_0000;
        fw[3] = -64'sh0E_0000;
        fw[4] = 64'h06_0000;
        send_frame(1, 1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        tick_expect(1'b1);

        // Tick coincident with the final word is ignored
        rand_words(10);
        send_frame(2, 2, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("busy_holds_in_pend", busy, 1);
            chk("no_commit_in_pend", commit, 0);
        end
        tick_expect(1'b1);

        // Early in_last: abort, no commit, shadow rolled back
        send(make_hdr(0, 2), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, (i == 3), 1'b0);
        chk("err_early_last", err, 1);
        tick_expect(1'b0);
        tick_expect(1'b0);
        chk("err_sticky", err, 1);
        rand_words(5);
        send_frame(2, 1, 1'b0, 1'b0);
        tick_expect(1'b1);

        // Bad header (range overflow) drains to in_last
        send(make_hdr(3, 2), 1'b0, 1'b0);
        chk("err_bad_hdr", err, 1);
        chk("busy_drain", busy, 1);
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, (i == 2), 1'b0);
        tick_expect(1'b0);
        chk("err_after_drain", err, 1);

        // Zero-count header carrying in_last
        send(make_hdr(0, 0), 1'b1, 1'b0);
        chk("err_m_zero", err, 1);
        tick_expect(1'b0);

        // Full-bank frame at the upper boundary
        rand_words(NW);
        send_frame(0, NSEC, 1'b0, 1'b0);
        tick_expect(1'b1);

`ifdef COEF_CHECKSUM_EN
        rand_words(10);
        send_frame(1, 2, 1'b0, 1'b0);
        tick_expect(1'b1);
        send_frame(1, 2, 1'b1, 1'b0);
        chk("err_bad_sum", err, 1);
        tick_expect(1'b0);
        tick_expect(1'b0);
`endif

        // Randomized valid frames
        for (int r = 0; r < 6; r++) begin
            s = $urandom_range(0, NSEC - 1);
            m = $urandom_range(1, NSEC - s);
            rand_words(5 * m);
            send_frame(s, m, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            tick_expect(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iir_coef_loader.md
# iir_coef_loader

Runtime coefficient loader for a cascade of 2nd-order IIR sections. Accepts framed coefficient words over a valid/ready stream, assembles them in a shadow bank, and atomically commits the shadow bank to the active bank on a filter sample boundary. The active bank drives the b0/b1/b2/a1/a2 inputs of up to NSEC sections. This makes filter retuning possible without resynthesis or file reload.

## Interface
- BITWIDTH, 32: sample width of the filter; every coefficient word is CW = 2*BITWIDTH bits, signed, scaled by 2^FAC upstream.
- NSEC, 4: number of sections served (1..255).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  CW  header, coefficient or checksum word.
- in_last  in  1  final word of frame.
- sample_tick  in  1  one-cycle pulse marking a filter sample boundary.
- coef  out  NSEC*5*CW  active bank.
  - Section s, word k sits at [(5*s+k)*CW +: CW].
  - k order: b0, b1, b2, a1, a2.
- commit  out  1  one-cycle pulse; active bank changed this cycle.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky frame error; cleared when the next header is accepted.

## Operation
- A word transfers when in_valid && in_ready.
- in_ready = !rst && state ∈ {IDLE, LOAD, CHECK, DRAIN}.
- Frame format:
  - Header: S = in_data[7:0] (start section), M = in_data[15:8] (section count). Other bits are ignored.
  - 5*M coefficient words follow, section S first, k order within each section.
- FSM:
  - IDLE: accept the header.
    - Valid when M≥1 and S+M≤NSEC: latch S/M, clear word counter, go to LOAD.
    - Invalid: set err, go to DRAIN, or RESYNC if the header carries in_last.
    - A header with in_last is an error.
  - LOAD: each accepted word writes the shadow entry (5*(S+n/5) + n%5), where n is the word counter.
    - in_last must be high exactly on word 5*M-1.
    - Early in_last: set err, go to RESYNC.
    - Missing in_last on the final word: set err, go to DRAIN.
    - Final word correct: go to PEND (CHECK when COEF_CHECKSUM_EN).
  - CHECK: accept one word with in_last.
    - Match: go to PEND.
    - Mismatch, or in_last low: set err; go to RESYNC on in_last, DRAIN otherwise.
  - PEND: on sample_tick, active ← shadow (entire bank), commit=1 on the same edge's output, go to IDLE.
  - DRAIN: discard words until in_last is accepted, then go to RESYNC.
  - RESYNC: shadow ← active (one cycle), go to IDLE. Aborted frames therefore never leak partial data into a later commit.
- Sections outside [S, S+M) keep their prior values through a commit.

## Timing
- Reset values:
  - coef = 0, shadow = 0.
  - commit = 0, err = 0, busy = 0.
  - in_ready = 0 while rst is high, 1 on the first cycle after release.
- Reset mid-frame or in PEND: frame discarded, banks zeroed.
- Throughput: one word per cycle in IDLE/LOAD/CHECK/DRAIN. A full 4-section frame (21 words) takes 21 cycles with in_valid held high.
- Commit latency: minimum 1 cycle after the final word.
  - sample_tick coincident with the final-word transfer is ignored; the commit uses the next tick.
  - coef updates on the clock edge that samples sample_tick while in PEND; commit is high for that following cycle only.
- in_ready = 0 in PEND and RESYNC; upstream stalls until the commit or resync completes.
- err sets on the edge that detects the error; it stays high through DRAIN/RESYNC until the next header transfer.

## Configuration
- COEF_CHECKSUM_EN defined:
  - Frame carries one trailing checksum word: the CW-bit wrapping sum of the header and all coefficient words.
  - The final coefficient word must have in_last=0.
  - The checksum word must have in_last=1.
  - Mismatch → err, shadow restored, no commit.
- COEF_CHECKSUM_EN undefined:
  - CHECK state and adder are absent.
  - The final coefficient word carries in_last; LOAD goes directly to PEND.

## Test plan
- Reset behaviour: rst for 3 cycles, then idle → coef all 0, commit/err/busy 0, and in_ready 1 on the first cycle after release.
- Single-section load: header S=1, M=1, then words 0x100000, 0x200000, 0x100000, -0xE0000, 0x60000 (last on the 5th); sample_tick 4 cycles later.
  - Section 1 updates on that edge, with commit pulsing exactly one cycle.
  - Sections 0, 2 and 3 stay 0.
- Tick coincident with the final word: no commit on that cycle; commit occurs on the following tick, and busy stays high in between.
- Early in_last: header S=0, M=2, with in_last on word 3 → err=1, no commit on later ticks. Shadow is restored, so a subsequent valid S=2, M=1 frame commits only section 2 and leaves sections 0/1 at their prior values.
- Bad header: S=3, M=2 with NSEC=4 → err, DRAIN discards until in_last. The next valid header clears err.
- With COEF_CHECKSUM_EN: a correct checksum commits; the same frame with checksum+1 sets err and never commits.
